reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_bank_pkg.sv | 7 +
 rtl/reg_bank.sv | 29 ++
 rtl/reg_bank_arbiter.sv | 82 ++++++++
 tb/tb_reg_bank_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults and FSM state type for the arbitrated register bank
package reg_bank_pkg;
    localparam int NREQ_DEF = 4;
    localparam int AW_DEF = 3;
    localparam int DW_DEF = 8;
    typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/reg_bank.sv
// reg_bank: 2**AW x DW register file, one write port, combinational read and full-bank view
module reg_bank #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [DW-1:0]          wdata,
    input  logic [AW-1:0]          raddr,
    output logic [DW-1:0]          rdata,
    output logic [(2**AW)*DW-1:0]  bank_q
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int k = 0; k < 2**AW; k++) mem[k] <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

    for (genvar k = 0; k < 2**AW; k++) begin : g_view
        assign bank_q[k*DW +: DW] = mem[k];
    end
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbitration of NREQ requesters onto a shared register bank
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*AW-1:0]     addr,
    input  logic [NREQ*DW-1:0]     wdata,
    output logic [NREQ-1:0]        gnt,
    output logic                   ack,
    output logic [DW-1:0]          rdata,
    output logic [(2**AW)*DW-1:0]  bank_q
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

    state_t        state;
    logic [PW-1:0] ptr, cur, pick;
    logic          any, hit;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;

    // Descending scan so the requester closest to ptr is assigned last and wins
    always_comb begin
        any = 1'b0;
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[PW'((int'(ptr) + i) % NREQ)]) begin
                any = 1'b1;
                pick = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    assign hit = state == ACCESS && req[cur];
    assign a = addr[cur*AW +: AW];
    assign wd = wdata[cur*DW +: DW];

    reg_bank #(.AW(AW), .DW(DW)) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (hit && we[cur]),
        .waddr  (a),
        .wdata  (wd),
        .raddr  (a),
        .rdata  (rd),
        .bank_q (bank_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            cur <= '0;
            gnt <= '0;
            ack <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= 1'b0;
            if (state == IDLE) begin
                if (any) begin
                    gnt <= NREQ'(1) << pick;
                    cur <= pick;
                    state <= ACCESS;
                end
            end else begin
                gnt <= '0;
                state <= IDLE;
                if (req[cur]) begin
                    ack <= 1'b1;
                    rdata <= we[cur] ? wd : rd;
                    ptr <= cur == PW'(NREQ - 1) ? '0 : cur + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed vectors with hand-computed expectations for the arbiter
module tb_reg_bank_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [11:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  rdata;
    logic [63:0] bank_q;
    int checks = 0;
    int errors = 0;

    reg_bank_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .rdata  (rdata),
        .bank_q (bank_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic w, input logic [2:0] a, input logic [7:0] d);
        we[i] = w;
        addr[i*3 +: 3] = a;
        wdata[i*8 +: 8] = d;
    endtask

    function automatic logic [7:0] reg_at(input int k);
        return bank_q[k*8 +: 8];
    endfunction

    initial begin
        tick();
        tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_ack", ack, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_bank", bank_q, 64'h0);
        rst_n = 1'b1;

        // single write by requester 2
        set_port(2, 1'b1, 3'd5, 8'hA5);
        req = 4'b0100;
        tick();
        chk("wr_gnt", gnt, 4'b0100);
        chk("wr_ack0", ack, 1'b0);
        tick();
        chk("wr_ack", ack, 1'b1);
        chk("wr_gnt_clr", gnt, 4'b0000);
        chk("wr_rdata", rdata, 8'hA5);
        chk("wr_reg5", reg_at(5), 8'hA5);
        req = '0;

        // read-back by requester 0 (ptr=3 wraps to 0)
        set_port(0, 1'b0, 3'd5, 8'h00);
        req = 4'b0001;
        tick();
        chk("rd_gnt", gnt, 4'b0001);
        tick();
        chk("rd_ack", ack, 1'b1);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_bank", bank_q, 64'h0000_A500_0000_0000);
        req = '0;
        tick();
        chk("rd_ack_pulse", ack, 1'b0);

        // fairness from fresh reset
        rst_n = 1'b0;
        #1;
        chk("rst2_bank", bank_q, 64'h0);
        tick();
        rst_n = 1'b1;
        we = '0;
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk($sformatf("fair_gnt%0d", t), gnt, 4'b0001 << (t % 4));
            chk($sformatf("fair_nack%0d", t), ack, 1'b0);
            tick();
            chk($sformatf("fair_ack%0d", t), ack, 1'b1);
            chk($sformatf("fair_gclr%0d", t), gnt, 4'b0000);
        end
        req = '0;
        tick();

        // abandon: requester 1 drops during ACCESS
        set_port(1, 1'b1, 3'd3, 8'h3C);
        req = 4'b0010;
        tick();
        chk("ab_gnt", gnt, 4'b0010);
        req = '0;
        tick();
        chk("ab_ack", ack, 1'b0);
        chk("ab_gnt_clr", gnt, 4'b0000);
        chk("ab_reg3", reg_at(3), 8'h00);
        set_port(3, 1'b0, 3'd0, 8'h00);
        req = 4'b1010;
        tick();
        chk("ab_ptr_gnt", gnt, 4'b0010);
        tick();
        chk("ab_done_ack", ack, 1'b1);
        chk("ab_done_reg3", reg_at(3), 8'h3C);
        chk("ab_done_rdata", rdata, 8'h3C);
        req = '0;
        tick();

        // reset during ACCESS of a write to reg7
        set_port(3, 1'b1, 3'd7, 8'hFF);
        req = 4'b1000;
        tick();
        chk("mr_gnt", gnt, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("mr_gnt0", gnt, 4'b0000);
        chk("mr_ack0", ack, 1'b0);
        chk("mr_reg7", reg_at(7), 8'h00);
        chk("mr_bank", bank_q, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_rel_ack", ack, 1'b0);
        chk("mr_rel_gnt", gnt, 4'b1000);
        req = '0;
        tick();
        chk("mr_drop_ack", ack, 1'b0);
        chk("mr_drop_reg7", reg_at(7), 8'h00);

        // wrap: move ptr to 3, then req=1001
        set_port(2, 1'b0, 3'd0, 8'h00);
        req = 4'b0100;
        tick();
        chk("wp_pre_gnt", gnt, 4'b0100);
        tick();
        chk("wp_pre_ack", ack, 1'b1);
        set_port(0, 1'b1, 3'd1, 8'h5A);
        set_port(3, 1'b1, 3'd2, 8'h66);
        req = 4'b1001;
        tick();
        chk("wp_gnt3", gnt, 4'b1000);
        tick();
        chk("wp_ack3", ack, 1'b1);
        chk("wp_rdata3", rdata, 8'h66);
        tick();
        chk("wp_gnt0", gnt, 4'b0001);
        tick();
        chk("wp_ack0", ack, 1'b1);
        chk("wp_rdata0", rdata, 8'h5A);
        chk("wp_bank", bank_q, 64'h0000_0000_0066_5A00);
        req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
